// File: rtl/bus_ctrl_pkg.sv
// Shared encodings for the bus control sequencer: opcodes, FSM states
// and the index-to-one-hot helper used by the register strobe decoders.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LDI  = 2'd0,
    OP_ADDI = 2'd1,
    OP_MV   = 2'd2,
    OP_ADD  = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Widest register file the decoder supports (index width up to 6).
  localparam int MAX_NREGS = 64;

  function automatic logic [MAX_NREGS-1:0] idx2onehot(
    input int unsigned idx
  );
    logic [MAX_NREGS-1:0] v;
    v = MAX_NREGS'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/bus_ctrl_seq_onehot_dec.sv
// Register index to one-hot strobe decoder with an in-range flag;
// out-of-range indices yield an all-zero vector and valid=0.
module onehot_dec
  import bus_ctrl_pkg::*;
#(
  parameter int IDX_W = 2,
  parameter int NREGS = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [NREGS-1:0] oh,
  output logic             valid
);

  logic [MAX_NREGS-1:0] full;
  logic                 hi_hit;

  assign full = idx2onehot(32'(idx));

  // Any set bit at or above NREGS means the index is out of range.
  if (NREGS < MAX_NREGS) begin : g_part
    assign hi_hit = |full[MAX_NREGS-1:NREGS];
  end else begin : g_full
    assign hi_hit = 1'b0;
  end

  assign valid = ~hi_hit;
  assign oh    = valid ? full[NREGS-1:0] : '0;

endmodule

// File: rtl/bus_ctrl_seq.sv
// Single-bus datapath control sequencer: steps LDI/ADDI/MV/ADD through
// T0..T2 with registered (Moore) strobes and a one-cycle done pulse.
module bus_ctrl_seq
  import bus_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [1:0]        opcode,
  input  logic [IDX_W-1:0]  rd,
  input  logic [IDX_W-1:0]  rs,
  input  logic [IDX_W-1:0]  rt,
  input  logic [DATA_W-1:0] imm,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic              Yin,
  output logic              Zin,
  output logic              Zout,
  output logic              ImmOut,
  output logic [DATA_W-1:0] ImmData,
  output logic [DATA_W-1:0] AddImm,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  state_e              state_q, state_d;
  opcode_e             op_q, op_d;
  logic [IDX_W-1:0]    rd_q, rd_d;
  logic [IDX_W-1:0]    rs_q, rs_d;
  logic [IDX_W-1:0]    rt_q, rt_d;
  logic [DATA_W-1:0]   imm_q, imm_d;

  logic [NREGS-1:0]    rin_q, rin_d;
  logic [NREGS-1:0]    rout_q, rout_d;
  logic                yin_q, yin_d;
  logic                zin_q, zin_d;
  logic                zout_q, zout_d;
  logic                immout_q, immout_d;
  logic [DATA_W-1:0]   immdata_q, immdata_d;
  logic [DATA_W-1:0]   addimm_q, addimm_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;

  logic                idle;
  opcode_e             op_c;
  logic [IDX_W-1:0]    rd_c, rs_c, rt_c;
  logic [DATA_W-1:0]   imm_c;
  logic [NREGS-1:0]    rd_oh, rs_oh, rt_oh;
  logic                rd_ok, rs_ok, rt_ok;
  logic                legal;

  // In IDLE the live inputs are the operands about to be latched.
  assign idle  = (state_q == S_IDLE);
  assign op_c  = idle ? opcode_e'(opcode) : op_q;
  assign rd_c  = idle ? rd  : rd_q;
  assign rs_c  = idle ? rs  : rs_q;
  assign rt_c  = idle ? rt  : rt_q;
  assign imm_c = idle ? imm : imm_q;

  onehot_dec #(.IDX_W(IDX_W), .NREGS(NREGS)) u_dec_rd (
    .idx   (rd_c),
    .oh    (rd_oh),
    .valid (rd_ok)
  );

  onehot_dec #(.IDX_W(IDX_W), .NREGS(NREGS)) u_dec_rs (
    .idx   (rs_c),
    .oh    (rs_oh),
    .valid (rs_ok)
  );

  onehot_dec #(.IDX_W(IDX_W), .NREGS(NREGS)) u_dec_rt (
    .idx   (rt_c),
    .oh    (rt_oh),
    .valid (rt_ok)
  );

  // Only the indices an opcode actually uses are range-checked.
  always_comb begin
    legal = 1'b0;
    unique case (op_c)
      OP_LDI:  legal = rd_ok;
      OP_ADDI: legal = rd_ok & rs_ok;
      OP_MV:   legal = rd_ok & rs_ok;
      OP_ADD:  legal = rd_ok & rs_ok & rt_ok;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    imm_d   = imm_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && legal) begin
          state_d = S_T0;
          op_d    = op_c;
          rd_d    = rd;
          rs_d    = rs;
          rt_d    = rt;
          imm_d   = imm;
        end
      end
      S_T0: begin
        unique case (op_q)
          OP_LDI, OP_MV: state_d = S_DONE;
          default:       state_d = S_T1;
        endcase
      end
      S_T1:    state_d = (op_q == OP_ADD) ? S_T2 : S_DONE;
      S_T2:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are a function of the state being entered, then registered.
  always_comb begin
    rin_d     = '0;
    rout_d    = '0;
    yin_d     = 1'b0;
    zin_d     = 1'b0;
    zout_d    = 1'b0;
    immout_d  = 1'b0;
    immdata_d = '0;
    addimm_d  = '0;
    done_d    = 1'b0;
    busy_d    = (state_d != S_IDLE);
    illegal_d = idle & start & ~legal;
    unique case (state_d)
      S_T0: begin
        unique case (op_c)
          OP_LDI: begin
            immout_d  = 1'b1;
            immdata_d = imm_c;
            rin_d     = rd_oh;
          end
          OP_MV: begin
            rout_d = rs_oh;
            rin_d  = rd_oh;
          end
          OP_ADDI: begin
            rout_d   = rs_oh;
            addimm_d = imm_c;
            zin_d    = 1'b1;
          end
          OP_ADD: begin
            rout_d = rs_oh;
            yin_d  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T1: begin
        if (op_c == OP_ADD) begin
          rout_d = rt_oh;
          zin_d  = 1'b1;
        end else begin
          zout_d = 1'b1;
          rin_d  = rd_oh;
        end
      end
      S_T2: begin
        zout_d = 1'b1;
        rin_d  = rd_oh;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      op_q      <= OP_LDI;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      rin_q     <= '0;
      rout_q    <= '0;
      yin_q     <= 1'b0;
      zin_q     <= 1'b0;
      zout_q    <= 1'b0;
      immout_q  <= 1'b0;
      immdata_q <= '0;
      addimm_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      imm_q     <= imm_d;
      rin_q     <= rin_d;
      rout_q    <= rout_d;
      yin_q     <= yin_d;
      zin_q     <= zin_d;
      zout_q    <= zout_d;
      immout_q  <= immout_d;
      immdata_q <= immdata_d;
      addimm_q  <= addimm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign Rin     = rin_q;
  assign Rout    = rout_q;
  assign Yin     = yin_q;
  assign Zin     = zin_q;
  assign Zout    = zout_q;
  assign ImmOut  = immout_q;
  assign ImmData = immdata_q;
  assign AddImm  = addimm_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_bus_ctrl_seq.sv
// Bench for bus_ctrl_seq: a 4-register and a 3-register instance share
// stimulus and are checked every cycle against an instruction-level model.
module tb_bus_ctrl_seq;

  logic       clock = 1'b0;
  logic       clear;
  logic       start;
  logic [1:0] opcode;
  logic [1:0] rd, rs, rt;
  logic [7:0] imm;

  logic [3:0] rin4, rout4;
  logic       yin4, zin4, zout4, immout4, busy4, done4, ill4;
  logic [7:0] immdata4, addimm4;
  logic [2:0] rin3, rout3;
  logic       yin3, zin3, zout3, immout3, busy3, done3, ill3;
  logic [7:0] immdata3, addimm3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bus_ctrl_seq #(.DATA_W(8), .NREGS(4)) u4 (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .Rin(rin4), .Rout(rout4), .Yin(yin4), .Zin(zin4), .Zout(zout4),
    .ImmOut(immout4), .ImmData(immdata4), .AddImm(addimm4),
    .busy(busy4), .done(done4), .illegal(ill4)
  );

  bus_ctrl_seq #(.DATA_W(8), .NREGS(3)) u3 (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .Rin(rin3), .Rout(rout3), .Yin(yin3), .Zin(zin3), .Zout(zout3),
    .ImmOut(immout3), .ImmData(immdata3), .AddImm(addimm3),
    .busy(busy3), .done(done3), .illegal(ill3)
  );

  // flags = {Yin, Zin, Zout, ImmOut, busy, done, illegal}
  typedef struct packed {
    logic [3:0] rin;
    logic [3:0] rout;
    logic [6:0] flags;
    logic [7:0] immdata;
    logic [7:0] addimm;
  } frame_t;

  frame_t act [2];
  frame_t expf [2];
  frame_t seq [2][8];
  int     len [2];
  int     pos [2];

  assign act[0] = {rin4, rout4,
                   yin4, zin4, zout4, immout4, busy4, done4, ill4,
                   immdata4, addimm4};
  assign act[1] = {1'b0, rin3, 1'b0, rout3,
                   yin3, zin3, zout3, immout3, busy3, done3, ill3,
                   immdata3, addimm3};

  function automatic frame_t mk(input logic [3:0] ri, input logic [3:0] ro,
                                input logic [6:0] fl, input logic [7:0] di,
                                input logic [7:0] da);
    return {ri, ro, fl, di, da};
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  function automatic bit legal_op(input int n, input logic [1:0] op,
                                  input logic [1:0] d, input logic [1:0] s,
                                  input logic [1:0] t);
    bit ok_d, ok_s, ok_t;
    ok_d = int'(d) < n;
    ok_s = int'(s) < n;
    ok_t = int'(t) < n;
    case (op)
      2'd0:    return ok_d;
      2'd1:    return ok_d && ok_s;
      2'd2:    return ok_d && ok_s;
      default: return ok_d && ok_s && ok_t;
    endcase
  endfunction

  task automatic push(input int k, input frame_t f);
    seq[k][len[k]] = f;
    len[k]++;
  endtask

  // One frame per cycle: the T-steps, the done cycle, then one idle cycle.
  task automatic build(input int k, input logic [1:0] op, input logic [1:0] d,
                       input logic [1:0] s, input logic [1:0] t,
                       input logic [7:0] i);
    len[k] = 0;
    case (op)
      2'd0: push(k, mk(oh(d), 4'h0, 7'b0001100, i, 8'h00));
      2'd2: push(k, mk(oh(d), oh(s), 7'b0000100, 8'h00, 8'h00));
      2'd1: begin
        push(k, mk(4'h0, oh(s), 7'b0100100, 8'h00, i));
        push(k, mk(oh(d), 4'h0, 7'b0010100, 8'h00, 8'h00));
      end
      default: begin
        push(k, mk(4'h0, oh(s), 7'b1000100, 8'h00, 8'h00));
        push(k, mk(4'h0, oh(t), 7'b0100100, 8'h00, 8'h00));
        push(k, mk(oh(d), 4'h0, 7'b0010100, 8'h00, 8'h00));
      end
    endcase
    push(k, mk(4'h0, 4'h0, 7'b0000110, 8'h00, 8'h00));
    push(k, '0);
  endtask

  always @(posedge clock or posedge clear) begin
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        len[k]  = 0;
        pos[k]  = 0;
        expf[k] = '0;
      end else if (pos[k] < len[k]) begin
        expf[k] = seq[k][pos[k]];
        pos[k]++;
      end else begin
        len[k]  = 0;
        pos[k]  = 0;
        expf[k] = '0;
        if (start) begin
          if (legal_op((k == 0) ? 4 : 3, opcode, rd, rs, rt)) begin
            build(k, opcode, rd, rs, rt, imm);
            expf[k] = seq[k][0];
            pos[k]  = 1;
          end else begin
            expf[k] = mk(4'h0, 4'h0, 7'b0000001, 8'h00, 8'h00);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!clear) begin
      for (int k = 0; k < 2; k++) begin
        int drv;
        checks++;
        if (act[k] !== expf[k]) begin
          errors++;
          $display("FAIL cycle_cmp dut%0d t=%0t got %h want %h",
                   k, $time, act[k], expf[k]);
        end
        drv = $countones(act[k].rout) + int'(act[k].flags[4])
            + int'(act[k].flags[3]);
        checks++;
        if (drv > 1) begin
          errors++;
          $display("FAIL bus_excl dut%0d t=%0t drivers %0d want <=1",
                   k, $time, drv);
        end
      end
    end
  end

  task automatic chkf(input string nm, input int k, input frame_t want);
    checks++;
    if (act[k] !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", nm, k, act[k], want);
    end
    checks++;
    if (expf[k] !== want) begin
      errors++;
      $display("FAIL %s model%0d got %h want %h", nm, k, expf[k], want);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Present one instruction for a single accepting edge, then scramble inputs.
  task automatic issue(input logic [1:0] op, input logic [1:0] d,
                       input logic [1:0] s, input logic [1:0] t,
                       input logic [7:0] i);
    @(negedge clock);
    opcode = op; rd = d; rs = s; rt = t; imm = i;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    opcode = ~op; rd = ~d; rs = ~s; rt = ~t; imm = ~i;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (!busy4 && !busy3) return;
      @(negedge clock);
    end
    checks++;
    errors++;
    $display("FAIL wait_idle timeout busy4=%b busy3=%b want 0", busy4, busy3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t want finish earlier", $time);
    $fatal(1);
  end

  initial begin
    clear = 1'b1; start = 1'b0; opcode = 2'd0;
    rd = 2'd0; rs = 2'd0; rt = 2'd0; imm = 8'h00;
    repeat (2) @(negedge clock);
    chkf("reset", 0, '0);
    chkf("reset", 1, '0);
    clear = 1'b0;

    // LDI r0, 0x05
    issue(2'd0, 2'd0, 2'd0, 2'd0, 8'h05);
    chkf("ldi_t0", 0, mk(4'b0001, 4'h0, 7'b0001100, 8'h05, 8'h00));
    step();
    chkf("ldi_done", 0, mk(4'h0, 4'h0, 7'b0000110, 8'h00, 8'h00));
    step();
    chkf("ldi_idle", 0, '0);

    // ADDI r1, r0, 0x05 (rt=3 unused, legal even with 3 regs)
    issue(2'd1, 2'd1, 2'd0, 2'd3, 8'h05);
    chkf("addi_t0", 0, mk(4'h0, 4'b0001, 7'b0100100, 8'h00, 8'h05));
    chkf("addi_t0_n3", 1, mk(4'h0, 4'b0001, 7'b0100100, 8'h00, 8'h05));
    step();
    chkf("addi_t1", 0, mk(4'b0010, 4'h0, 7'b0010100, 8'h00, 8'h00));
    step();
    chkf("addi_done", 0, mk(4'h0, 4'h0, 7'b0000110, 8'h00, 8'h00));
    step();

    // ADD r3, r1, r2 (rd=3 illegal on the 3-register instance)
    issue(2'd3, 2'd3, 2'd1, 2'd2, 8'h00);
    chkf("add_t0", 0, mk(4'h0, 4'b0010, 7'b1000100, 8'h00, 8'h00));
    chkf("add_ill_n3", 1, mk(4'h0, 4'h0, 7'b0000001, 8'h00, 8'h00));
    step();
    chkf("add_t1", 0, mk(4'h0, 4'b0100, 7'b0100100, 8'h00, 8'h00));
    chkf("add_ill_gone_n3", 1, '0);
    step();
    chkf("add_t2", 0, mk(4'b1000, 4'h0, 7'b0010100, 8'h00, 8'h00));
    step();
    chkf("add_done", 0, mk(4'h0, 4'h0, 7'b0000110, 8'h00, 8'h00));
    step();

    // MV r3, r0
    issue(2'd2, 2'd3, 2'd0, 2'd0, 8'h00);
    chkf("mv_t0", 0, mk(4'b1000, 4'b0001, 7'b0000100, 8'h00, 8'h00));
    chkf("mv_ill_n3", 1, mk(4'h0, 4'h0, 7'b0000001, 8'h00, 8'h00));
    step();
    chkf("mv_done", 0, mk(4'h0, 4'h0, 7'b0000110, 8'h00, 8'h00));
    chkf("mv_nodone_n3", 1, '0);
    step();

    // clear in the middle of ADD T1, then MV r2, r1
    issue(2'd3, 2'd0, 2'd1, 2'd2, 8'h00);
    step();
    #2 clear = 1'b1;
    #1;
    chkf("clr_async", 0, '0);
    chkf("clr_async", 1, '0);
    @(negedge clock);
    clear = 1'b0;
    issue(2'd2, 2'd2, 2'd1, 2'd0, 8'h00);
    chkf("mv2_t0", 0, mk(4'b0100, 4'b0010, 7'b0000100, 8'h00, 8'h00));
    chkf("mv2_t0", 1, mk(4'b0100, 4'b0010, 7'b0000100, 8'h00, 8'h00));
    step();
    chkf("mv2_done", 0, mk(4'h0, 4'h0, 7'b0000110, 8'h00, 8'h00));
    step();

    // start held across ADDI r2, r1, 0x07; opcode switched while busy
    @(negedge clock);
    opcode = 2'd1; rd = 2'd2; rs = 2'd1; rt = 2'd0; imm = 8'h07;
    start = 1'b1;
    @(negedge clock);
    chkf("hold_t0", 0, mk(4'h0, 4'b0010, 7'b0100100, 8'h00, 8'h07));
    opcode = 2'd0; rd = 2'd3; imm = 8'h33;
    step();
    chkf("hold_t1", 0, mk(4'b0100, 4'h0, 7'b0010100, 8'h00, 8'h00));
    step();
    chkf("hold_done", 0, mk(4'h0, 4'h0, 7'b0000110, 8'h00, 8'h00));
    step();
    chkf("hold_idle", 0, '0);
    step();
    chkf("hold_next", 0, mk(4'b1000, 4'h0, 7'b0001100, 8'h33, 8'h00));
    start = 1'b0;
    wait_idle(8);

    // ADD r1, r1, r1 and immediate boundaries
    issue(2'd3, 2'd1, 2'd1, 2'd1, 8'h00);
    wait_idle(8);
    issue(2'd0, 2'd3, 2'd0, 2'd0, 8'hFF);
    wait_idle(8);
    issue(2'd1, 2'd0, 2'd3, 2'd0, 8'hFF);
    wait_idle(8);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_ctrl_seq.md
BUS_CTRL_SEQ -- requirements
Module: bus_ctrl_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath/immediate width.
REQ-002 SHALL have parameter NREGS, default 4, number of general registers on the bus; IDX_W = clog2(NREGS), minimum 1.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  request to execute one instruction; sampled only in IDLE.
REQ-006 SHALL have port opcode  in  2  0=LDI rd,imm; 1=ADDI rd,rs,imm; 2=MV rd,rs; 3=ADD rd,rs,rt.
REQ-007 SHALL have ports rd, rs, rt  in  IDX_W each  register indices.
REQ-008 SHALL have port imm  in  DATA_W  immediate operand.
REQ-009 SHALL have port Rin  out  NREGS  one-hot register load strobes.
REQ-010 SHALL have port Rout  out  NREGS  one-hot register bus-drive strobes.
REQ-011 SHALL have ports Yin, Zin, Zout  out  1 each  ALU operand latch, result latch, result bus-drive.
REQ-012 SHALL have ports ImmOut  out  1, ImmData  out  DATA_W, and AddImm  out  DATA_W; these drive the immediate onto the bus and the ALU immediate input, respectively.
REQ-013 SHALL have ports busy, done, illegal  out  1 each  status.

Function
REQ-014 Operands opcode/rd/rs/rt/imm SHALL be latched on the edge at which start is accepted; later input changes SHALL have no effect until the next acceptance.
REQ-015 FSM states SHALL be IDLE, T0, T1, T2, DONE; all outputs SHALL be registered (Moore), with no combinational path from inputs to outputs.
REQ-016 IDLE: start=1 with legal indices SHALL transition to T0; start=0 SHALL remain in IDLE.
REQ-017 LDI: T0 SHALL assert ImmOut=1, ImmData=imm, Rin[rd]=1; the FSM SHALL then go to DONE.
REQ-018 MV: T0 SHALL assert Rout[rs]=1 and Rin[rd]=1; the FSM SHALL then go to DONE.
REQ-019 ADDI: T0 SHALL assert Rout[rs]=1, AddImm=imm, Zin=1; T1 SHALL assert Zout=1 and Rin[rd]=1; the FSM SHALL then go to DONE.
REQ-020 ADD: T0 SHALL assert Rout[rs]=1 and Yin=1; T1 SHALL assert Rout[rt]=1 and Zin=1 (AddImm=0); T2 SHALL assert Zout=1 and Rin[rd]=1; the FSM SHALL then go to DONE.
REQ-021 Strobes not listed for a state SHALL be 0; ImmData and AddImm SHALL be 0 whenever not in use.
REQ-022 Bus exclusivity: at most one of {any Rout bit, Zout, ImmOut} SHALL be 1 in any cycle.
REQ-023 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE; start present during DONE SHALL be ignored.
REQ-024 busy SHALL be 1 in T0..T2 and DONE, and 0 in IDLE.
REQ-025 Latency from the accepting edge to done SHALL be LDI/MV 2 cycles, ADDI 3 cycles, ADD 4 cycles.
REQ-026 Any used index >= NREGS SHALL produce illegal=1 for one cycle with no strobes asserted, and the FSM SHALL remain in IDLE; unused indices (e.g. rt for ADDI) SHALL NOT be checked.
REQ-027 rd equal to rs or rt SHALL be legal, with no special handling.
REQ-028 start asserted while busy SHALL be ignored, neither queued nor flagged.

Reset
REQ-029 clear=1 SHALL immediately force state=IDLE and all outputs to 0, including mid-instruction.
REQ-030 The first start accepted after clear deasserts SHALL execute normally; an instruction interrupted by clear SHALL NOT be resumed.

Structure
REQ-031 Opcode encodings, the state encoding, and an index-to-one-hot function SHALL reside in shared package bus_ctrl_pkg.
REQ-032 A single sub-module, onehot_dec (IDX_W -> NREGS, with out-of-range valid flag), SHALL be instantiated for Rin/Rout generation and index checking.

Verification
REQ-033 After clear, LDI rd=0, imm=8'h05 SHALL give T0: ImmOut=1, ImmData=8'h05, Rin=4'b0001; done on the 2nd edge.
REQ-034 ADDI rd=1, rs=0, imm=8'h05 SHALL give T0: Rout=4'b0001, Zin=1, AddImm=8'h05; T1: Zout=1, Rin=4'b0010; done on the 3rd edge.
REQ-035 ADD rd=3, rs=1, rt=2 SHALL give T0: Rout=0010, Yin; T1: Rout=0100, Zin; T2: Zout, Rin=1000; done on the 4th edge; the bus-exclusivity check SHALL hold every cycle.
REQ-036 With NREGS=3, MV rd=3 SHALL give illegal for one cycle with all strobes 0, busy=0, and no done.
REQ-037 Asserting clear during ADD T1 SHALL drop all outputs to 0 asynchronously; a following MV rd=2, rs=1 SHALL complete with done after 2 edges.
REQ-038 Holding start=1 continuously across an ADDI SHALL result in the second instruction being accepted only in the cycle after done, and opcode changes while busy SHALL leave the executing sequence unaltered.
